// File: rtl/phasecalc_cordic_if.sv
// Request/result bundle between the I/Q source and the phase calculator.
// The master drives start/x/y; the slave (the converter) returns the polar result.
interface phasecalc_cordic_if #(
    parameter int INSIZE  = 13,
    parameter int OUTSIZE = 19
);
    logic                      start;
    logic signed [INSIZE-1:0]  x;
    logic signed [INSIZE-1:0]  y;
    logic                      busy;
    logic                      done;
    logic signed [OUTSIZE-1:0] angle;
    logic [INSIZE+1:0]         magnitude;
    logic                      zero;

    modport master (
        output start, x, y,
        input  busy, done, angle, magnitude, zero
    );

    modport slave (
        input  start, x, y,
        output busy, done, angle, magnitude, zero
    );
endinterface

// File: rtl/phasecalc_cordic.sv
// Four-quadrant rectangular-to-polar converter built on an iterative vectoring CORDIC.
// Angle is degrees*1024 in (-180, +180]; magnitude carries the uncompensated CORDIC gain.
module phasecalc_cordic #(
    parameter int INSIZE     = 13,
    parameter int OUTSIZE    = 19,
    parameter int ITERATIONS = 16,
    parameter int CNTSIZE    = 5
) (
    input  logic              clock,
    input  logic              reset,
    phasecalc_cordic_if.slave bus
);

    localparam int W = INSIZE + 2;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ITER   = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    localparam logic signed [OUTSIZE-1:0] HALF_TURN = OUTSIZE'(180 * 1024);

    // atan(2^-i) in degrees*1024, rounded to nearest
    localparam int ATAN_TAB [16] = '{46080, 27203, 14373, 7296, 3662, 1833, 917, 458,
                                     229, 115, 57, 29, 14, 7, 4, 2};

    logic [1:0]                state_q, state_d;
    logic signed [W-1:0]       xr_q, xr_d;
    logic signed [W-1:0]       yr_q, yr_d;
    logic signed [OUTSIZE-1:0] acc_q, acc_d;
    logic [CNTSIZE-1:0]        cnt_q, cnt_d;
    logic                      zflag_q, zflag_d;
    logic signed [OUTSIZE-1:0] angle_q, angle_d;
    logic [W-1:0]              mag_q, mag_d;
    logic                      zero_q, zero_d;
    logic                      done_q, done_d;

    logic signed [W-1:0]       xIn;
    logic signed [W-1:0]       yIn;
    logic signed [W-1:0]       xShift;
    logic signed [W-1:0]       yShift;
    logic signed [OUTSIZE-1:0] atanStep;

    assign xIn      = {{2{bus.x[INSIZE-1]}}, bus.x};
    assign yIn      = {{2{bus.y[INSIZE-1]}}, bus.y};
    assign xShift   = xr_q >>> cnt_q;
    assign yShift   = yr_q >>> cnt_q;
    assign atanStep = OUTSIZE'(ATAN_TAB[cnt_q[3:0]]);

    always_comb begin
        state_d = state_q;
        xr_d    = xr_q;
        yr_d    = yr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        zflag_d = zflag_q;
        angle_d = angle_q;
        mag_d   = mag_q;
        zero_d  = zero_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // Left half-plane vectors are rotated by 180 degrees so the
                    // CORDIC only ever sees x >= 0.
                    if (!bus.x[INSIZE-1]) begin
                        xr_d  = xIn;
                        yr_d  = yIn;
                        acc_d = '0;
                    end else begin
                        xr_d  = -xIn;
                        yr_d  = -yIn;
                        acc_d = bus.y[INSIZE-1] ? -HALF_TURN : HALF_TURN;
                    end
                    cnt_d   = '0;
                    zflag_d = (bus.x == '0) && (bus.y == '0);
                    state_d = ITER;
                end
            end

            ITER: begin
                if (!yr_q[W-1]) begin
                    xr_d  = xr_q + yShift;
                    yr_d  = yr_q - xShift;
                    acc_d = acc_q + atanStep;
                end else begin
                    xr_d  = xr_q - yShift;
                    yr_d  = yr_q + xShift;
                    acc_d = acc_q - atanStep;
                end
                cnt_d = cnt_q + CNTSIZE'(1);
                if (cnt_q == CNTSIZE'(ITERATIONS - 1)) begin
                    state_d = FINISH;
                end
            end

            FINISH: begin
                // -180 is folded onto +180 to keep the range half-open at the bottom
                angle_d = (acc_q == -HALF_TURN) ? HALF_TURN : acc_q;
                mag_d   = xr_q;
                if (zflag_q) begin
                    angle_d = '0;
                    mag_d   = '0;
                end
                zero_d  = zflag_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            xr_q    <= '0;
            yr_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            zflag_q <= 1'b0;
            angle_q <= '0;
            mag_q   <= '0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            zflag_q <= zflag_d;
            angle_q <= angle_d;
            mag_q   <= mag_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.angle     = angle_q;
    assign bus.magnitude = mag_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_phasecalc_cordic.sv
// Bench for phasecalc_cordic: a reference CORDIC result is queued for every accepted
// start and compared, together with a loose ideal atan2/sqrt check, when done pulses.
module tb_phasecalc_cordic;

    localparam int  INSIZE     = 13;
    localparam int  OUTSIZE    = 19;
    localparam int  ITERATIONS = 16;
    localparam int  CNTSIZE    = 5;
    localparam int  LATENCY    = ITERATIONS + 1;
    localparam int  PERIOD_CYC = ITERATIONS + 2;
    localparam real PI         = 3.14159265358979;
    localparam real KGAIN      = 1.646760258;
    localparam real ANGLE_TOL  = 256.0;
    localparam real MAG_TOL    = 10.0;

    typedef struct {
        int x;
        int y;
        int angle;
        int mag;
        bit zero;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    exp_t sbQ[$];

    phasecalc_cordic_if #(.INSIZE(INSIZE), .OUTSIZE(OUTSIZE)) bus ();

    phasecalc_cordic #(
        .INSIZE(INSIZE),
        .OUTSIZE(OUTSIZE),
        .ITERATIONS(ITERATIONS),
        .CNTSIZE(CNTSIZE)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    // Independent integer model of the vectoring algorithm, evaluated on acceptance
    function automatic exp_t refModel(int x, int y);
        int tab [16] = '{46080, 27203, 14373, 7296, 3662, 1833, 917, 458,
                         229, 115, 57, 29, 14, 7, 4, 2};
        exp_t e;
        int xr, yr, acc, xn, yn;
        e.x = x;
        e.y = y;
        if (x >= 0) begin
            xr = x; yr = y; acc = 0;
        end else begin
            xr = -x; yr = -y; acc = (y >= 0) ? 184320 : -184320;
        end
        for (int i = 0; i < ITERATIONS; i++) begin
            if (yr >= 0) begin
                xn = xr + (yr >>> i); yn = yr - (xr >>> i); acc = acc + tab[i];
            end else begin
                xn = xr - (yr >>> i); yn = yr + (xr >>> i); acc = acc - tab[i];
            end
            xr = xn;
            yr = yn;
        end
        if (acc == -184320) acc = 184320;
        e.zero  = (x == 0) && (y == 0);
        e.angle = e.zero ? 0 : acc;
        e.mag   = e.zero ? 0 : xr;
        return e;
    endfunction

    always @(posedge clock) begin
        if (reset && bus.start && !bus.busy)
            sbQ.push_back(refModel(int'(bus.x), int'(bus.y)));
    end

    function automatic real absReal(real v);
        return (v < 0.0) ? -v : v;
    endfunction

    // Drives one start pulse, scrambles x/y while busy and waits (bounded) for done
    task automatic runConversion(input int xv, input int yv, output bit got, output int lat);
        int e0;
        got = 1'b0;
        lat = 0;
        @(negedge clock);
        bus.start = 1'b1;
        bus.x     = INSIZE'(xv);
        bus.y     = INSIZE'(yv);
        @(posedge clock);
        #1;
        e0 = cycle;
        @(negedge clock);
        bus.start = 1'b0;
        bus.x     = INSIZE'($urandom);
        bus.y     = INSIZE'($urandom);
        for (int c = 0; c < 40; c++) begin
            @(posedge clock);
            #1;
            if (bus.done) begin
                got = 1'b1;
                lat = cycle - e0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.x     = '0;
        bus.y     = '0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
        checks++;
        if (bus.zero !== 1'b0) begin errors++; $display("[TB] FAIL reset_zero: got %b expected 0", bus.zero); end
        checks++;
        if (bus.angle !== '0) begin errors++; $display("[TB] FAIL reset_angle: got %0d expected 0", bus.angle); end
        checks++;
        if (bus.magnitude !== '0) begin errors++; $display("[TB] FAIL reset_magnitude: got %0d expected 0", bus.magnitude); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_axes();
        int vx [4] = '{1000, 0, 0, -1000};
        int vy [4] = '{0, 1000, -1000, 0};
        for (int k = 0; k < 4; k++) begin
            bit   got;
            int   lat;
            exp_t e;
            real  dA, dM;
            runConversion(vx[k], vy[k], got, lat);
            checks++;
            if (!got || sbQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL axes_done[%0d]: got no result in 40 cycles, expected done after %0d", k, LATENCY);
            end else begin
                e = sbQ.pop_front();
                checks++;
                if (lat != LATENCY) begin errors++; $display("[TB] FAIL axes_latency[%0d]: got %0d expected %0d", k, lat, LATENCY); end
                checks++;
                if (int'(bus.angle) !== e.angle) begin errors++; $display("[TB] FAIL axes_angle[%0d]: got %0d expected %0d", k, bus.angle, e.angle); end
                checks++;
                if (int'(bus.magnitude) !== e.mag) begin errors++; $display("[TB] FAIL axes_mag[%0d]: got %0d expected %0d", k, bus.magnitude, e.mag); end
                dA = absReal(real'(int'(bus.angle)) - $atan2(real'(vy[k]), real'(vx[k])) * 180.0 / PI * 1024.0);
                checks++;
                if (dA > ANGLE_TOL) begin errors++; $display("[TB] FAIL axes_ideal_angle[%0d]: got %0d off by %0f", k, bus.angle, dA); end
                dM = absReal(real'(int'(bus.magnitude)) - $sqrt(real'(vx[k] * vx[k] + vy[k] * vy[k])) * KGAIN);
                checks++;
                if (dM > MAG_TOL) begin errors++; $display("[TB] FAIL axes_ideal_mag[%0d]: got %0d off by %0f", k, bus.magnitude, dM); end
            end
        end
    endtask

    task automatic test_reset_abort();
        bit sawDone;
        sawDone = 1'b0;
        @(negedge clock);
        bus.start = 1'b1;
        bus.x     = INSIZE'(700);
        bus.y     = INSIZE'(300);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (5) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        sbQ.delete();
        @(posedge clock);
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", bus.busy); end
        checks++;
        if (bus.angle !== '0) begin errors++; $display("[TB] FAIL abort_angle: got %0d expected 0", bus.angle); end
        checks++;
        if (bus.magnitude !== '0) begin errors++; $display("[TB] FAIL abort_magnitude: got %0d expected 0", bus.magnitude); end
        for (int c = 0; c < 25; c++) begin
            @(posedge clock);
            #1;
            if (bus.done) sawDone = 1'b1;
        end
        checks++;
        if (sawDone) begin errors++; $display("[TB] FAIL abort_done: got a done pulse, expected none"); end
    endtask

    task automatic test_quadrants();
        int vx [6] = '{-1000, -1000, 1000, 700, -4096, -4096};
        int vy [6] = '{-1000, 1000, -1000, -2500, -4096, -1};
        for (int k = 0; k < 6; k++) begin
            bit   got;
            int   lat;
            exp_t e;
            real  dA, dM;
            runConversion(vx[k], vy[k], got, lat);
            checks++;
            if (!got || sbQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL quad_done[%0d]: got no result in 40 cycles, expected done after %0d", k, LATENCY);
            end else begin
                e = sbQ.pop_front();
                checks++;
                if (int'(bus.angle) !== e.angle) begin errors++; $display("[TB] FAIL quad_angle[%0d]: got %0d expected %0d", k, bus.angle, e.angle); end
                checks++;
                if (int'(bus.magnitude) !== e.mag) begin errors++; $display("[TB] FAIL quad_mag[%0d]: got %0d expected %0d", k, bus.magnitude, e.mag); end
                dA = absReal(real'(int'(bus.angle)) - $atan2(real'(vy[k]), real'(vx[k])) * 180.0 / PI * 1024.0);
                checks++;
                if (dA > ANGLE_TOL) begin errors++; $display("[TB] FAIL quad_ideal_angle[%0d]: got %0d off by %0f", k, bus.angle, dA); end
                dM = absReal(real'(int'(bus.magnitude)) - $sqrt(real'(vx[k] * vx[k] + vy[k] * vy[k])) * KGAIN);
                checks++;
                if (dM > MAG_TOL) begin errors++; $display("[TB] FAIL quad_ideal_mag[%0d]: got %0d off by %0f", k, bus.magnitude, dM); end
                if (vy[k] < 0) begin
                    checks++;
                    if (!(int'(bus.angle) < 0)) begin errors++; $display("[TB] FAIL quad_sign[%0d]: got %0d expected negative", k, bus.angle); end
                end
            end
        end
    endtask

    task automatic test_zero();
        int vx [2] = '{0, 5};
        int vy [2] = '{0, 5};
        for (int k = 0; k < 2; k++) begin
            bit   got;
            int   lat;
            exp_t e;
            runConversion(vx[k], vy[k], got, lat);
            checks++;
            if (!got || sbQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL zero_done[%0d]: got no result in 40 cycles, expected done after %0d", k, LATENCY);
            end else begin
                e = sbQ.pop_front();
                checks++;
                if (bus.zero !== e.zero) begin errors++; $display("[TB] FAIL zero_flag[%0d]: got %b expected %b", k, bus.zero, e.zero); end
                checks++;
                if (int'(bus.angle) !== e.angle) begin errors++; $display("[TB] FAIL zero_angle[%0d]: got %0d expected %0d", k, bus.angle, e.angle); end
                checks++;
                if (int'(bus.magnitude) !== e.mag) begin errors++; $display("[TB] FAIL zero_mag[%0d]: got %0d expected %0d", k, bus.magnitude, e.mag); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int vx [4] = '{1500, -2000, -100, 4095};
        int vy [4] = '{800, 300, -3000, -4096};
        int doneAt [4];
        @(negedge clock);
        bus.start = 1'b1;
        bus.x     = INSIZE'(vx[0]);
        bus.y     = INSIZE'(vy[0]);
        for (int k = 0; k < 4; k++) begin
            bit   got;
            exp_t e;
            got = 1'b0;
            for (int c = 0; c < 40; c++) begin
                @(posedge clock);
                #1;
                if (bus.done) begin
                    got = 1'b1;
                    break;
                end
            end
            doneAt[k] = cycle;
            checks++;
            if (!got || sbQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL b2b_done[%0d]: got no result in 40 cycles, expected one every %0d", k, PERIOD_CYC);
            end else begin
                e = sbQ.pop_front();
                checks++;
                if (int'(bus.angle) !== e.angle) begin errors++; $display("[TB] FAIL b2b_angle[%0d]: got %0d expected %0d", k, bus.angle, e.angle); end
                checks++;
                if (int'(bus.magnitude) !== e.mag) begin errors++; $display("[TB] FAIL b2b_mag[%0d]: got %0d expected %0d", k, bus.magnitude, e.mag); end
            end
            @(negedge clock);
            if (k < 3) begin
                bus.x = INSIZE'(vx[k + 1]);
                bus.y = INSIZE'(vy[k + 1]);
            end else begin
                bus.start = 1'b0;
            end
        end
        for (int k = 1; k < 4; k++) begin
            checks++;
            if (doneAt[k] - doneAt[k - 1] != PERIOD_CYC) begin
                errors++;
                $display("[TB] FAIL b2b_period[%0d]: got %0d cycles expected %0d", k, doneAt[k] - doneAt[k - 1], PERIOD_CYC);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int   e0, lat;
        bit   got, extraDone;
        exp_t e;
        got       = 1'b0;
        extraDone = 1'b0;
        lat       = 0;
        @(negedge clock);
        bus.start = 1'b1;
        bus.x     = INSIZE'(1200);
        bus.y     = INSIZE'(-500);
        @(posedge clock);
        #1;
        e0 = cycle;
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_high: got %b expected 1", bus.busy); end
        @(negedge clock);
        bus.start = 1'b0;
        bus.x     = INSIZE'($urandom);
        bus.y     = INSIZE'($urandom);
        repeat (4) @(negedge clock);
        bus.start = 1'b1;
        bus.x     = INSIZE'(-3000);
        bus.y     = INSIZE'(2000);
        @(negedge clock);
        bus.start = 1'b0;
        bus.x     = INSIZE'($urandom);
        bus.y     = INSIZE'($urandom);
        for (int c = 0; c < 40; c++) begin
            @(posedge clock);
            #1;
            if (bus.done) begin
                got = 1'b1;
                lat = cycle - e0;
                break;
            end
        end
        checks++;
        if (!got || sbQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL busy_done: got no result in 40 cycles, expected done after %0d", LATENCY);
        end else begin
            e = sbQ.pop_front();
            checks++;
            if (lat != LATENCY) begin errors++; $display("[TB] FAIL busy_latency: got %0d expected %0d", lat, LATENCY); end
            checks++;
            if (int'(bus.angle) !== e.angle) begin errors++; $display("[TB] FAIL busy_angle: got %0d expected %0d", bus.angle, e.angle); end
            checks++;
            if (int'(bus.magnitude) !== e.mag) begin errors++; $display("[TB] FAIL busy_mag: got %0d expected %0d", bus.magnitude, e.mag); end
        end
        for (int c = 0; c < 30; c++) begin
            @(posedge clock);
            #1;
            if (bus.done) extraDone = 1'b1;
        end
        checks++;
        if (extraDone) begin errors++; $display("[TB] FAIL busy_dropped: got a second done, expected the busy start to be dropped"); end
    endtask

    initial begin
        test_reset();
        test_axes();
        test_reset_abort();
        test_quadrants();
        test_zero();
        test_back_to_back();
        test_busy_ignore();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation time limit, expected all tests to complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
